// File: rtl/demux1to2_32bit_buf_pkg.sv
// Shared constants for the buffered 1-to-2 stream demultiplexer.
package demux_pkg;

    localparam int DEMUX_WIDTH = 32;
    localparam int DEMUX_DEPTH = 2;

    localparam logic SEL_OUT0 = 1'b0;
    localparam logic SEL_OUT1 = 1'b1;

    localparam int CNT_W = 16;

    // Transfer counters wrap naturally from all-ones back to zero.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cnt);
        return cnt + 16'd1;
    endfunction

endpackage

// File: rtl/demux1to2_32bit_buf_stream_fifo.sv
// Registered-output synchronous FIFO: the head word, valid and full flags all come
// straight from flops, so a push is never visible at the output in the same cycle.
module stream_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int DEPTH = DEMUX_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             full_q, full_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    // A full FIFO refuses pushes even when it is popped in the same cycle.
    assign push_ok_s = push_i & ~full_q;
    assign pop_ok_s  = pop_i & valid_q;

    // Next-state computation for storage, pointers, occupancy and output registers.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase
        full_d  = (occ_d == OCC_FULL);
        valid_d = (occ_d != {OCC_W{1'b0}});
        // When empty this still tracks the slot under the read pointer.
        head_d  = mem_d[rd_ptr_d];
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            full_q   <= 1'b0;
            valid_q  <= 1'b0;
            head_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            full_q   <= full_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
        end
    end

    assign full_o  = full_q;
    assign valid_o = valid_q;
    assign head_o  = head_q;

endmodule

// File: rtl/demux1to2_32bit_buf.sv
// Buffered 1-to-2 stream demultiplexer: routes each input word by in_sel into one of
// two independent output FIFOs. Define DEMUX_STATS_EN to add per-port transfer counters.
module demux1to2_32bit_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int DEPTH = DEMUX_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data
`ifdef DEMUX_STATS_EN
    ,
    output logic [CNT_W-1:0] out0_cnt,
    output logic [CNT_W-1:0] out1_cnt
`endif
);

    logic full0_s, full1_s;
    logic push0_s, push1_s;
    logic pop0_s, pop1_s;

    // Ready looks only at the registered full flag of the addressed FIFO.
    assign in_ready = (in_sel == SEL_OUT1) ? ~full1_s : ~full0_s;

    assign push0_s = in_valid & in_ready & (in_sel == SEL_OUT0);
    assign push1_s = in_valid & in_ready & (in_sel == SEL_OUT1);
    assign pop0_s  = out0_valid & out0_ready;
    assign pop1_s  = out1_valid & out1_ready;

    stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push0_s),
        .push_data_i (in_data),
        .pop_i       (pop0_s),
        .full_o      (full0_s),
        .valid_o     (out0_valid),
        .head_o      (out0_data)
    );

    stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push1_s),
        .push_data_i (in_data),
        .pop_i       (pop1_s),
        .full_o      (full1_s),
        .valid_o     (out1_valid),
        .head_o      (out1_data)
    );

`ifdef DEMUX_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    // Count completed output transfers on each port.
    always_comb begin
        if (pop0_s) begin
            cnt0_d = cnt_inc(cnt0_q);
        end else begin
            cnt0_d = cnt0_q;
        end
        if (pop1_s) begin
            cnt1_d = cnt_inc(cnt1_q);
        end else begin
            cnt1_d = cnt1_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign out0_cnt = cnt0_q;
    assign out1_cnt = cnt1_q;
`else
    // Without statistics the design carries no counter state.
`endif

endmodule

// File: tb/tb_demux1to2_32bit_buf.sv
// Scoreboard bench for demux1to2_32bit_buf: per-port expected-word queues fed on accepted
// pushes, checked by a monitor sampling 1 time unit before every rising edge.
module tb_demux1to2_32bit_buf;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sel;
    logic [31:0] in_data;
    logic        out0_valid;
    logic        out0_ready;
    logic [31:0] out0_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [31:0] out1_data;
`ifdef DEMUX_STATS_EN
    logic [15:0] out0_cnt;
    logic [15:0] out1_cnt;
`endif

    demux1to2_32bit_buf dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data)
`ifdef DEMUX_STATS_EN
        ,
        .out0_cnt   (out0_cnt),
        .out1_cnt   (out1_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: queue contents per port plus completed-transfer tallies.
    logic [31:0] m0[$];
    logic [31:0] m1[$];
    int unsigned pops0 = 0;
    int unsigned pops1 = 0;

    bit rnd0 = 1'b0;
    bit rnd1 = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: sample just before the rising edge, compare, then advance the model.
    bit          prev_stall = 1'b0;
    logic        prev_sel;
    logic [31:0] prev_data;
    always @(negedge clk) begin
        #4;
        if (!rst_n) begin
            m0.delete();
            m1.delete();
            pops0 = 0;
            pops1 = 0;
            prev_stall = 1'b0;
            chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
            chk("rst_out0_valid", {63'd0, out0_valid}, 64'd0);
            chk("rst_out1_valid", {63'd0, out1_valid}, 64'd0);
            chk("rst_out0_data", {32'd0, out0_data}, 64'd0);
            chk("rst_out1_data", {32'd0, out1_data}, 64'd0);
        end else begin
            if (prev_stall && in_valid)
                assert (in_sel == prev_sel && in_data == prev_data)
                else $error("producer changed sel/data while stalled");
            chk("in_ready", {63'd0, in_ready},
                {63'd0, ((in_sel ? m1.size() : m0.size()) < DEPTH)});
            chk("out0_valid", {63'd0, out0_valid}, {63'd0, (m0.size() != 0)});
            chk("out1_valid", {63'd0, out1_valid}, {63'd0, (m1.size() != 0)});
            if (out0_valid && m0.size() != 0) chk("out0_data", {32'd0, out0_data}, {32'd0, m0[0]});
            if (out1_valid && m1.size() != 0) chk("out1_data", {32'd0, out1_data}, {32'd0, m1[0]});
`ifdef DEMUX_STATS_EN
            chk("out0_cnt", {48'd0, out0_cnt}, {48'd0, pops0[15:0]});
            chk("out1_cnt", {48'd0, out1_cnt}, {48'd0, pops1[15:0]});
`endif
            if (out0_valid && out0_ready && m0.size() != 0) begin
                void'(m0.pop_front());
                pops0++;
            end
            if (out1_valid && out1_ready && m1.size() != 0) begin
                void'(m1.pop_front());
                pops1++;
            end
            if (in_valid && in_ready) begin
                if (in_sel) m1.push_back(in_data);
                else        m0.push_back(in_data);
            end
            prev_stall = in_valid && !in_ready;
            prev_sel   = in_sel;
            prev_data  = in_data;
        end
    end

    // Random consumer backpressure when enabled.
    always @(negedge clk) begin
        #1;
        if (rnd0) out0_ready = 1'($urandom_range(0, 1));
        if (rnd1) out1_ready = 1'($urandom_range(0, 1));
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Present one word and hold it until accepted; reports stalled cycles.
    task automatic push(input logic s, input logic [31:0] d, output int waited);
        bit acc;
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
        waited   = 0;
        for (int k = 0; k < 300; k++) begin
            #3;
            acc = in_ready;
            tick();
            if (acc) break;
            waited++;
        end
        if (waited >= 300) begin
            n_cmp++;
            n_err++;
            $display("FAIL push_timeout: word %0h never accepted", d);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k;
        for (k = 0; k < 400; k++) begin
            if (m0.size() == 0 && m1.size() == 0) break;
            tick();
        end
        chk(name, {32'd0, 32'(m0.size() + m1.size())}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int w;
    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_sel     = 1'b0;
        in_data    = 32'd0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Basic routing with both consumers ready.
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        push(1'b0, 32'h5555_5555, w);
        push(1'b1, 32'hAAAA_AAAA, w);
        repeat (3) tick();
        wait_drain("basic_drain");
`ifdef DEMUX_STATS_EN
        #3;
        chk("basic_cnt0", {48'd0, out0_cnt}, 64'd1);
        chk("basic_cnt1", {48'd0, out1_cnt}, 64'd1);
        tick();
`endif

        // Order and backpressure on port 0.
        out0_ready = 1'b0;
        push(1'b0, 32'hD155_D555, w);
        push(1'b0, 32'h0000_0001, w);
        in_sel  = 1'b0;
        in_data = 32'h0BAD_0BAD;
        #3;
        chk("bp_ready_sel0", {63'd0, in_ready}, 64'd0);
        tick();
        push(1'b1, 32'h1111_2222, w);
        chk("bp_sel1_no_wait", 64'(w), 64'd0);
        out0_ready = 1'b1;
        repeat (4) tick();
        wait_drain("bp_drain");

        // Full FIFO0 popped while a sel=0 push is presented.
        out0_ready = 1'b0;
        push(1'b0, 32'hA0A0_0001, w);
        push(1'b0, 32'hA0A0_0002, w);
        out0_ready = 1'b1;
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        in_data    = 32'hA0A0_0003;
        #3;
        chk("fullpop_refused", {63'd0, in_ready}, 64'd0);
        tick();
        out0_ready = 1'b0;
        #3;
        chk("fullpop_accept_next", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        #3;
        chk("fullpop_full_again", {63'd0, in_ready}, 64'd0);
        tick();
        out0_ready = 1'b1;
        repeat (4) tick();
        wait_drain("fullpop_drain");

        // Pointer wrap: ten sequential words to port 1 under random backpressure.
        rnd1 = 1'b1;
        for (int i = 0; i < 10; i++) push(1'b1, 32'(i), w);
        repeat (20) tick();
        rnd1 = 1'b0;
        out1_ready = 1'b1;
        wait_drain("wrap_drain");

        // Random mixed traffic.
        rnd0 = 1'b1;
        rnd1 = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            push(1'($urandom_range(0, 1)), $urandom, w);
        end
        rnd0 = 1'b0;
        rnd1 = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        wait_drain("random_drain");

        // Asynchronous reset with both FIFOs holding data.
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        push(1'b0, 32'hDEAD_0000, w);
        push(1'b1, 32'hDEAD_0001, w);
        push(1'b0, 32'hDEAD_0002, w);
        rst_n = 1'b0;
        #1;
        chk("arst_out0_valid", {63'd0, out0_valid}, 64'd0);
        chk("arst_out1_valid", {63'd0, out1_valid}, 64'd0);
        chk("arst_out0_data", {32'd0, out0_data}, 64'd0);
        chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        out0_ready = 1'b1;
        push(1'b0, 32'h1234_5678, w);
        #3;
        chk("post_rst_valid", {63'd0, out0_valid}, 64'd1);
        chk("post_rst_first", {32'd0, out0_data}, 64'h1234_5678);
        tick();
        repeat (2) tick();
        wait_drain("post_rst_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
